// File: rtl/bc_disp_pkg.sv
// Shared types and constants for the Bulls & Cows display bus arbiter.
// Digits are 6-bit fields {enable, code[3:0], dp}; the bus packs d8..d1 MSB first.
package bc_disp_pkg;

   localparam int DIG_W       = 6;
   localparam int NUM_DIG     = 8;
   localparam int BUS_W       = DIG_W * NUM_DIG;
   localparam int DIG_EN      = 5;
   localparam int DIG_CODE_HI = 4;
   localparam int DIG_CODE_LO = 1;
   localparam int DIG_DP      = 0;

   // State encoding doubles as the src output value.
   typedef enum logic [1:0] {
      ST_GAME  = 2'd0,
      ST_WIN   = 2'd1,
      ST_SCORE = 2'd2,
      ST_OVER  = 2'd3
   } disp_state_e;

   localparam logic [3:0] CODE_ONE = 4'd1;
   localparam logic [3:0] CODE_TWO = 4'd2;
   localparam logic [3:0] CODE_P   = 4'hC;

   localparam logic [DIG_W-1:0] DIG_BLANK = 6'd0;

   function automatic logic [DIG_W-1:0] mk_digit(input logic [3:0] code);
      logic [DIG_W-1:0] d;
      d                          = DIG_BLANK;
      d[DIG_EN]                  = 1'b1;
      d[DIG_CODE_HI:DIG_CODE_LO] = code;
      d[DIG_DP]                  = 1'b0;
      return d;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   localparam logic [BUS_W-1:0] BUS_BLANK = {NUM_DIG{DIG_BLANK}};
   localparam logic [BUS_W-1:0] BANNER_P1 = {mk_digit(CODE_P), mk_digit(CODE_ONE), {6{DIG_BLANK}}};
   localparam logic [BUS_W-1:0] BANNER_P2 = {mk_digit(CODE_P), mk_digit(CODE_TWO), {6{DIG_BLANK}}};

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that stops at zero; expired is high while the count is zero.
module hold_timer #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/disp_arbiter.sv
// Time-shares the 8-digit display bus between game digits, score digits and a
// winner banner, and runs the end-of-match blink view.
module disp_arbiter
   import bc_disp_pkg::*;
#(
   parameter int WIN_HOLD   = 200_000_000,
   parameter int SCORE_HOLD = 300_000_000,
   parameter int BLINK_HALF = 50_000_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [BUS_W-1:0] game_dig,
   input  logic [BUS_W-1:0] score_dig,
   input  logic             p1_win,
   input  logic             p2_win,
   input  logic             score_req,
   input  logic             game_over,
   output logic [BUS_W-1:0] out_dig,
   output logic [1:0]       src,
   output logic             busy
);

   localparam int TW = $clog2(max3(WIN_HOLD, SCORE_HOLD, BLINK_HALF));

   localparam logic [TW-1:0] WIN_LD   = TW'(WIN_HOLD - 1);
   localparam logic [TW-1:0] SCORE_LD = TW'(SCORE_HOLD - 1);
   localparam logic [TW-1:0] BLINK_LD = TW'(BLINK_HALF - 1);

   disp_state_e      state_q, state_d;
   logic             winner_q, winner_d;   // 0 = player 1, 1 = player 2
   logic             phase_q, phase_d;     // blink phase: 0 = score, 1 = blank
   logic [BUS_W-1:0] out_dig_q, out_dig_d;
   logic [1:0]       src_q, src_d;
   logic             busy_q, busy_d;

   logic             tmr_load;
   logic [TW-1:0]    tmr_val;
   logic             tmr_expired;

   hold_timer #(.W(TW)) u_hold_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   wire any_win = p1_win | p2_win;

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      phase_d  = phase_q;
      tmr_load = 1'b0;
      tmr_val  = '0;

      case (state_q)
         ST_GAME: begin
            if (any_win) begin
               state_d  = ST_WIN;
               tmr_load = 1'b1;
               tmr_val  = WIN_LD;
               winner_d = ~p1_win;
            end else if (game_over) begin
               state_d  = ST_OVER;
               tmr_load = 1'b1;
               tmr_val  = BLINK_LD;
               phase_d  = 1'b0;
            end else if (score_req) begin
               state_d  = ST_SCORE;
               tmr_load = 1'b1;
               tmr_val  = SCORE_LD;
            end
         end

         ST_WIN: begin
            if (tmr_expired) begin
               if (game_over) begin
                  state_d  = ST_OVER;
                  tmr_load = 1'b1;
                  tmr_val  = BLINK_LD;
                  phase_d  = 1'b0;
               end else begin
                  state_d = ST_GAME;
               end
            end
         end

         ST_SCORE: begin
            if (any_win) begin
               state_d  = ST_WIN;
               tmr_load = 1'b1;
               tmr_val  = WIN_LD;
               winner_d = ~p1_win;
            end else if (score_req) begin
               tmr_load = 1'b1;
               tmr_val  = SCORE_LD;
            end else if (tmr_expired) begin
               if (game_over) begin
                  state_d  = ST_OVER;
                  tmr_load = 1'b1;
                  tmr_val  = BLINK_LD;
                  phase_d  = 1'b0;
               end else begin
                  state_d = ST_GAME;
               end
            end
         end

         ST_OVER: begin
            // Terminal view: only the blink timer runs until reset.
            if (tmr_expired) begin
               phase_d  = ~phase_q;
               tmr_load = 1'b1;
               tmr_val  = BLINK_LD;
            end
         end

         default: begin
            state_d = ST_GAME;
         end
      endcase
   end

   // Outputs follow the next state so the bus changes one cycle after the cause.
   always_comb begin
      out_dig_d = BUS_BLANK;
      case (state_d)
         ST_GAME:  out_dig_d = game_dig;
         ST_WIN:   out_dig_d = winner_d ? BANNER_P2 : BANNER_P1;
         ST_SCORE: out_dig_d = score_dig;
         ST_OVER:  out_dig_d = phase_d ? BUS_BLANK : score_dig;
         default:  out_dig_d = BUS_BLANK;
      endcase
      src_d  = state_d;
      busy_d = (state_d == ST_WIN) || (state_d == ST_SCORE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_GAME;
         winner_q  <= 1'b0;
         phase_q   <= 1'b0;
         out_dig_q <= BUS_BLANK;
         src_q     <= 2'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         winner_q  <= winner_d;
         phase_q   <= phase_d;
         out_dig_q <= out_dig_d;
         src_q     <= src_d;
         busy_q    <= busy_d;
      end
   end

   assign out_dig = out_dig_q;
   assign src     = src_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with short hold times (WIN 8, SCORE 5, BLINK 3).
module tb_disp_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [47:0] game_dig;
   logic [47:0] score_dig;
   logic        p1_win;
   logic        p2_win;
   logic        score_req;
   logic        game_over;
   logic [47:0] out_dig;
   logic [1:0]  src;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   // "P" = code C, "1"/"2" = codes 1/2, enable bit set, d6..d1 blank.
   localparam logic [47:0] BP1 = {6'h38, 6'h22, 36'd0};
   localparam logic [47:0] BP2 = {6'h38, 6'h24, 36'd0};
   localparam logic [47:0] GD0 = 48'hABC_DEF_012_345;
   localparam logic [47:0] GD1 = 48'h123_456_789_ABC;
   localparam logic [47:0] SD0 = 48'h0A1_B2C_3D4_E5F;
   localparam logic [47:0] SD1 = 48'h555_AAA_333_CCC;

   disp_arbiter #(
      .WIN_HOLD   (8),
      .SCORE_HOLD (5),
      .BLINK_HALF (3)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .game_dig  (game_dig),
      .score_dig (score_dig),
      .p1_win    (p1_win),
      .p2_win    (p2_win),
      .score_req (score_req),
      .game_over (game_over),
      .out_dig   (out_dig),
      .src       (src),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_view(input string tag, input logic [47:0] e_dig,
                           input logic [1:0] e_src, input logic e_busy);
      chk({tag, ".dig"}, out_dig, e_dig);
      chk({tag, ".src"}, {46'd0, src}, {46'd0, e_src});
      chk({tag, ".busy"}, {47'd0, busy}, {47'd0, e_busy});
   endtask

   initial begin
      reset     = 1'b1;
      game_dig  = GD0;
      score_dig = SD0;
      p1_win    = 1'b0;
      p2_win    = 1'b0;
      score_req = 1'b0;
      game_over = 1'b0;

      // Reset and steady game view
      repeat (3) step();
      chk_view("reset", 48'd0, 2'd0, 1'b0);
      reset = 1'b0;
      step();
      chk_view("game0", GD0, 2'd0, 1'b0);
      game_dig = GD1;
      chk_view("game_lat_old", GD0, 2'd0, 1'b0);
      step();
      chk_view("game_lat_new", GD1, 2'd0, 1'b0);

      // p1 banner for exactly 8 cycles
      p1_win = 1'b1;
      step();
      p1_win = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         chk_view($sformatf("p1_ban%0d", i), BP1, 2'd1, 1'b1);
         step();
      end
      chk_view("p1_back", GD1, 2'd0, 1'b0);

      // Score view expires after 5 cycles, shows live score digits
      score_req = 1'b1;
      step();
      score_req = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         chk_view($sformatf("score%0d", i), (i >= 3) ? SD1 : SD0, 2'd2, 1'b1);
         if (i == 2) score_dig = SD1;
         step();
      end
      chk_view("score_back", GD1, 2'd0, 1'b0);
      score_dig = SD0;

      // Score re-arm at cycle 3 extends the view to 8 cycles
      score_req = 1'b1;
      step();
      score_req = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         chk_view($sformatf("rearm%0d", i), SD0, 2'd2, 1'b1);
         if (i == 3) score_req = 1'b1;
         step();
         score_req = 1'b0;
      end
      chk_view("rearm_back", GD1, 2'd0, 1'b0);

      // Score pre-empted by p2 win
      score_req = 1'b1;
      step();
      score_req = 1'b0;
      chk_view("pre_score1", SD0, 2'd2, 1'b1);
      step();
      chk_view("pre_score2", SD0, 2'd2, 1'b1);
      p2_win = 1'b1;
      step();
      p2_win = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         chk_view($sformatf("p2_ban%0d", i), BP2, 2'd1, 1'b1);
         step();
      end
      chk_view("p2_back", GD1, 2'd0, 1'b0);

      // Simultaneous wins -> P1; later p2 pulse neither changes nor extends
      p1_win = 1'b1;
      p2_win = 1'b1;
      step();
      p1_win = 1'b0;
      p2_win = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         chk_view($sformatf("both_ban%0d", i), BP1, 2'd1, 1'b1);
         if (i == 3) p2_win = 1'b1;
         step();
         p2_win = 1'b0;
      end
      chk_view("both_back", GD1, 2'd0, 1'b0);

      // Win with game_over -> banner then blinking OVER view
      p2_win    = 1'b1;
      game_over = 1'b1;
      step();
      p2_win = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         chk_view($sformatf("go_ban%0d", i), BP2, 2'd1, 1'b1);
         if (i == 2) score_req = 1'b1;
         step();
         score_req = 1'b0;
      end
      for (int k = 0; k < 12; k++) begin
         chk_view($sformatf("over%0d", k), (((k / 3) % 2) == 0) ? SD0 : 48'd0, 2'd3, 1'b0);
         if (k == 4) score_req = 1'b1;
         if (k == 7) p1_win = 1'b1;
         if (k == 8) game_over = 1'b0;
         step();
         score_req = 1'b0;
         p1_win    = 1'b0;
      end

      // Only reset leaves OVER
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_view("over_rst", 48'd0, 2'd0, 1'b0);
      step();
      chk_view("over_rst_game", GD1, 2'd0, 1'b0);

      // Reset in the middle of SCORE
      score_req = 1'b1;
      step();
      score_req = 1'b0;
      chk_view("mid_score1", SD0, 2'd2, 1'b1);
      step();
      chk_view("mid_score2", SD0, 2'd2, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_view("mid_rst", 48'd0, 2'd0, 1'b0);
      step();
      chk_view("mid_rst_game", GD1, 2'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
